// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
// Shared definitions for the normalizer's cross-core sum exchange.
//   - exchanged-sum width derivation from the activation width
//   - TX / RX handshake state encodings
//   - default round timeout
// -----------------------------------------------------------------------------
package norm_pkg;

    localparam int BW_DEFAULT      = 8;
    localparam int TIMEOUT_DEFAULT = 255;

    // Exchanged sum is the partial-sum width (2*bw+4) plus 4 guard bits.
    function automatic int sum_width(input int bw);
        return (2 * bw + 4) + 4;
    endfunction

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_REL  = 2'd2
    } tx_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_HOLD = 1'b1
    } rx_state_t;

endpackage

// File: rtl/hs4_rx.sv
// -----------------------------------------------------------------------------
// hs4_rx
// 4-phase receiver with a one-entry buffer. A request is only accepted while
// the buffer is empty; otherwise rx_ack stays low and the peer waits.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_rx_req        peer request
//   i_rx_data       peer data, captured on acceptance
//   i_consume       owner takes the buffered value this edge
//   o_rx_ack        acknowledge to peer
//   o_full          buffer holds an unconsumed value
//   o_data          buffered value
// -----------------------------------------------------------------------------
module hs4_rx
    import norm_pkg::*;
#(
    parameter int sw = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_rx_req,
    input  logic [sw-1:0] i_rx_data,
    input  logic          i_consume,
    output logic          o_rx_ack,
    output logic          o_full,
    output logic [sw-1:0] o_data
);

    rx_state_t     r_state;
    logic          r_ack;
    logic          r_full;
    logic [sw-1:0] r_data;
    logic          w_capture;

    assign w_capture = (r_state == R_IDLE) && i_rx_req && !r_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_ack   <= 1'b0;
            r_full  <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (w_capture) begin
                        r_data  <= i_rx_data;
                        r_ack   <= 1'b1;
                        r_state <= R_HOLD;
                    end
                end
                R_HOLD: begin
                    if (!i_rx_req) begin
                        r_ack   <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= R_IDLE;
                end
            endcase
            // A capture only happens into an empty buffer, so when it lands on
            // the same edge as a consume the new value must survive.
            if (w_capture)
                r_full <= 1'b1;
            else if (i_consume)
                r_full <= 1'b0;
        end
    end

    assign o_rx_ack = r_ack;
    assign o_full   = r_full;
    assign o_data   = r_data;

endmodule

// File: rtl/norm_sum_link.sv
// -----------------------------------------------------------------------------
// norm_sum_link
// Cross-core partner for the normalizer's sum exchange. Ships the local row
// sum to the peer over a 4-phase link, receives the peer's sum, and returns
// it to the normalizer once both directions are done. Solo mode skips the
// link; a timeout force-completes a round so the normalizer never hangs.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   solo                single-core mode, peer link ignored
//   loc_sum/_valid      local sum and round-start pulse
//   sum_in/_valid       peer sum to normalizer, one-cycle valid pulse
//   tx_data/req, tx_ack outgoing 4-phase link
//   rx_data/req, rx_ack incoming 4-phase link
//   busy                round open
//   err                 sticky timeout flag
//   round_cnt           completed rounds (wraps)
// -----------------------------------------------------------------------------
module norm_sum_link
    import norm_pkg::*;
#(
    parameter int bw      = BW_DEFAULT,
    parameter int bw_psum = 2 * bw + 4,
    parameter int sw      = bw_psum + 4,
    parameter int timeout = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          solo,
    input  logic [sw-1:0] loc_sum,
    input  logic          loc_sum_valid,
    output logic [sw-1:0] sum_in,
    output logic          sum_in_valid,
    output logic [sw-1:0] tx_data,
    output logic          tx_req,
    input  logic          tx_ack,
    input  logic [sw-1:0] rx_data,
    input  logic          rx_req,
    output logic          rx_ack,
    output logic          busy,
    output logic          err,
    output logic [15:0]   round_cnt
);

    // Counter value seen at the edge where the round has been open 'timeout' cycles.
    localparam logic [15:0] TO_LAST = 16'(timeout - 1);

    tx_state_t     r_tx_state;
    logic          r_tx_req;
    logic          r_tx_done;
    logic [sw-1:0] r_tx_data;
    logic          r_busy;
    logic          r_err;
    logic [15:0]   r_tcnt;
    logic [15:0]   r_rounds;
    logic [sw-1:0] r_sum_in;
    logic          r_sum_in_valid;

    logic          w_rx_full;
    logic [sw-1:0] w_rx_buf;
    logic          w_start;
    logic          w_done;
    logic          w_force;
    logic          w_complete;
    logic [sw-1:0] w_sum_next;

    hs4_rx #(.sw(sw)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .i_rx_req  (rx_req),
        .i_rx_data (rx_data),
        .i_consume (w_complete),
        .o_rx_ack  (rx_ack),
        .o_full    (w_rx_full),
        .o_data    (w_rx_buf)
    );

    // loc_sum_valid during an open round (including the completion edge) is dropped.
    assign w_start    = loc_sum_valid && !r_busy;
    assign w_done     = r_busy && r_tx_done && (w_rx_full || solo);
    // A regular completion on the timeout edge wins; err is only for rounds that stalled.
    assign w_force    = r_busy && !w_done && (r_tcnt == TO_LAST);
    assign w_complete = w_done || w_force;

    always_comb begin
        w_sum_next = '0;
        if (w_done)
            w_sum_next = solo ? '0 : w_rx_buf;
        else if (w_rx_full)
            w_sum_next = w_rx_buf;
    end

    // TX handshake; any completion (regular or forced) returns it to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= T_IDLE;
            r_tx_req   <= 1'b0;
            r_tx_done  <= 1'b0;
        end else if (w_complete) begin
            r_tx_state <= T_IDLE;
            r_tx_req   <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (w_start) begin
                        if (solo) begin
                            r_tx_done <= 1'b1;
                        end else begin
                            r_tx_state <= T_REQ;
                            r_tx_req   <= 1'b1;
                        end
                    end
                end
                T_REQ: begin
                    if (tx_ack) begin
                        r_tx_state <= T_REL;
                        r_tx_req   <= 1'b0;
                    end
                end
                T_REL: begin
                    if (!tx_ack) begin
                        r_tx_state <= T_IDLE;
                        r_tx_done  <= 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= T_IDLE;
                    r_tx_req   <= 1'b0;
                end
            endcase
        end
    end

    // Round bookkeeping: start latch, timeout counter, completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_data      <= '0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_tcnt         <= '0;
            r_rounds       <= '0;
            r_sum_in       <= '0;
            r_sum_in_valid <= 1'b0;
        end else begin
            r_sum_in_valid <= w_complete;
            if (w_complete) begin
                r_sum_in <= w_sum_next;
                r_busy   <= 1'b0;
                r_tcnt   <= '0;
                r_rounds <= r_rounds + 16'd1;
                if (w_force)
                    r_err <= 1'b1;
            end else if (w_start) begin
                r_tx_data <= loc_sum;
                r_busy    <= 1'b1;
                r_tcnt    <= '0;
            end else if (r_busy) begin
                r_tcnt <= r_tcnt + 16'd1;
            end
        end
    end

    assign sum_in       = r_sum_in;
    assign sum_in_valid = r_sum_in_valid;
    assign tx_data      = r_tx_data;
    assign tx_req       = r_tx_req;
    assign busy         = r_busy;
    assign err          = r_err;
    assign round_cnt    = r_rounds;

endmodule

// File: tb/tb_norm_sum_link.sv
// -----------------------------------------------------------------------------
// tb_norm_sum_link
// Two link instances, A and B. In mode 0 they are cross-wired peers; in mode 1
// A's peer is driven directly by the bench and B's link inputs are parked.
// Expected sum_in values and their arrival cycles are queued when a round is
// launched and popped when sum_in_valid appears.
// -----------------------------------------------------------------------------
module tb_norm_sum_link;

    localparam int SW = 24;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    logic          mode;
    logic          p_req, p_ack;
    logic [SW-1:0] p_data;

    logic          a_solo, b_solo, a_lsv, b_lsv;
    logic [SW-1:0] a_loc, b_loc;
    logic [SW-1:0] a_sum_in, b_sum_in, a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic          a_sum_in_valid, b_sum_in_valid;
    logic          a_tx_req, b_tx_req, a_tx_ack, b_tx_ack;
    logic          a_rx_req, b_rx_req, a_rx_ack, b_rx_ack;
    logic          a_busy, b_busy, a_err, b_err;
    logic [15:0]   a_round_cnt, b_round_cnt;

    assign a_rx_req  = mode ? p_req  : b_tx_req;
    assign a_rx_data = mode ? p_data : b_tx_data;
    assign a_tx_ack  = mode ? p_ack  : b_rx_ack;
    assign b_rx_req  = mode ? 1'b0   : a_tx_req;
    assign b_rx_data = a_tx_data;
    assign b_tx_ack  = mode ? 1'b0   : a_rx_ack;

    norm_sum_link #(.timeout(16)) u_a (
        .clk(clk), .reset(reset), .solo(a_solo),
        .loc_sum(a_loc), .loc_sum_valid(a_lsv),
        .sum_in(a_sum_in), .sum_in_valid(a_sum_in_valid),
        .tx_data(a_tx_data), .tx_req(a_tx_req), .tx_ack(a_tx_ack),
        .rx_data(a_rx_data), .rx_req(a_rx_req), .rx_ack(a_rx_ack),
        .busy(a_busy), .err(a_err), .round_cnt(a_round_cnt)
    );

    norm_sum_link #(.timeout(16)) u_b (
        .clk(clk), .reset(reset), .solo(b_solo),
        .loc_sum(b_loc), .loc_sum_valid(b_lsv),
        .sum_in(b_sum_in), .sum_in_valid(b_sum_in_valid),
        .tx_data(b_tx_data), .tx_req(b_tx_req), .tx_ack(b_tx_ack),
        .rx_data(b_rx_data), .rx_req(b_rx_req), .rx_ack(b_rx_ack),
        .busy(b_busy), .err(b_err), .round_cnt(b_round_cnt)
    );

    typedef struct {
        logic [SW-1:0] sum;
        int            cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Scoreboard: every valid pulse must match the head of its queue in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (a_sum_in_valid) begin
                if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_sum_in", a_sum_in, e.sum);
                    chk("a_valid_cyc", cyc, e.cyc);
                end
            end
            if (b_sum_in_valid) begin
                if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_sum_in", b_sum_in, e.sum);
                    chk("b_valid_cyc", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic saw;
        int   n;
        reset = 1'b1; mode = 1'b1;
        p_req = 0; p_ack = 0; p_data = '0;
        a_solo = 0; b_solo = 0; a_lsv = 0; b_lsv = 0; a_loc = '0; b_loc = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_valid", a_sum_in_valid, 0);
        chk("rst_sum", a_sum_in, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        chk("rst_txreq", a_tx_req, 0);
        chk("rst_rxack", a_rx_ack, 0);
        chk("rst_txdata", a_tx_data, 0);
        chk("rst_rounds", a_round_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

        // solo round
        a_solo = 1; a_loc = 24'h000123; a_lsv = 1;
        qa.push_back('{24'h0, cyc + 2});
        @(negedge clk); a_lsv = 0;
        saw = 0;
        repeat (6) begin
            if (a_tx_req) saw = 1;
            @(negedge clk);
        end
        chk("solo_txreq_seen", saw, 0);
        chk("solo_busy", a_busy, 0);
        chk("solo_rounds", a_round_cnt, 1);
        a_solo = 0;

        // peer loopback, both start together
        mode = 0;
        @(negedge clk);
        a_loc = 24'h000100; b_loc = 24'h000050; a_lsv = 1; b_lsv = 1;
        qa.push_back('{24'h000050, cyc + 6});
        qb.push_back('{24'h000100, cyc + 6});
        @(negedge clk); a_lsv = 0; b_lsv = 0;
        chk("lb_a_txreq", a_tx_req, 1);
        chk("lb_b_txreq", b_tx_req, 1);
        repeat (8) @(negedge clk);
        chk("lb_a_err", a_err, 0);
        chk("lb_b_err", b_err, 0);
        chk("lb_b_busy", b_busy, 0);

        // early peer: B starts 10 cycles ahead of A
        n = cyc;
        b_loc = 24'h0000BB; b_lsv = 1;
        @(negedge clk); b_lsv = 0;
        @(negedge clk);
        chk("early_a_ack", a_rx_ack, 1);
        repeat (8) @(negedge clk);
        chk("early_cyc", cyc, n + 10);
        a_loc = 24'h0000AA; a_lsv = 1;
        qa.push_back('{24'h0000BB, cyc + 6});
        qb.push_back('{24'h0000AA, cyc + 3});
        @(negedge clk); a_lsv = 0;
        repeat (8) @(negedge clk);
        chk("early_b_err", b_err, 0);
        chk("early_a_err", a_err, 0);

        // backpressure with a bench-driven peer
        mode = 1;
        @(negedge clk);
        p_data = 24'h000111; p_req = 1;
        for (int k = 0; k < 10 && !a_rx_ack; k++) @(negedge clk);
        chk("bp_ack1", a_rx_ack, 1);
        p_req = 0;
        for (int k = 0; k < 10 && a_rx_ack; k++) @(negedge clk);
        chk("bp_rel1", a_rx_ack, 0);
        p_data = 24'h000222; p_req = 1;
        saw = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_rx_ack) saw = 1;
        end
        chk("bp_ack_held_low", saw, 0);
        a_loc = 24'h000333; a_lsv = 1;
        qa.push_back('{24'h000111, cyc + 4});
        @(negedge clk); a_lsv = 0;
        chk("bp_txreq", a_tx_req, 1);
        chk("bp_txdata", a_tx_data, 24'h000333);
        p_ack = 1;
        @(negedge clk);
        chk("bp_txreq_rel", a_tx_req, 0);
        chk("bp_ack_lo2", a_rx_ack, 0);
        p_ack = 0;
        @(negedge clk);
        chk("bp_ack_lo3", a_rx_ack, 0);
        @(negedge clk);
        chk("bp_ack_lo_cmp", a_rx_ack, 0);
        @(negedge clk);
        chk("bp_ack2", a_rx_ack, 1);
        p_req = 0;
        @(negedge clk);
        chk("bp_rel2", a_rx_ack, 0);
        // drain the buffered second value with a solo round
        a_solo = 1; a_lsv = 1;
        qa.push_back('{24'h0, cyc + 2});
        @(negedge clk); a_lsv = 0;
        repeat (3) @(negedge clk);
        a_solo = 0;

        // timeout with a silent peer
        a_loc = 24'h000444; a_lsv = 1;
        qa.push_back('{24'h0, cyc + 17});
        @(negedge clk); a_lsv = 0;
        repeat (15) @(negedge clk);
        chk("to_err_pre", a_err, 0);
        chk("to_txreq_pre", a_tx_req, 1);
        @(negedge clk);
        chk("to_err", a_err, 1);
        chk("to_txreq_post", a_tx_req, 0);
        chk("to_busy_post", a_busy, 0);
        @(negedge clk);
        // new round after a timeout, peer behaves
        a_loc = 24'h000666; a_lsv = 1;
        p_data = 24'h000555; p_req = 1;
        qa.push_back('{24'h000555, cyc + 4});
        @(negedge clk); a_lsv = 0;
        chk("to2_busy", a_busy, 1);
        chk("to2_txreq", a_tx_req, 1);
        chk("to2_rxack", a_rx_ack, 1);
        chk("to2_txdata", a_tx_data, 24'h000666);
        p_ack = 1; p_req = 0;
        @(negedge clk);
        chk("to2_txreq_rel", a_tx_req, 0);
        p_ack = 0;
        repeat (4) @(negedge clk);
        chk("to2_err_sticky", a_err, 1);

        // reset in the middle of a handshake
        a_loc = 24'h000999; a_lsv = 1;
        @(negedge clk); a_lsv = 0;
        chk("mid_txreq_pre", a_tx_req, 1);
        reset = 1;
        @(negedge clk);
        chk("mid_txreq", a_tx_req, 0);
        chk("mid_rxack", a_rx_ack, 0);
        chk("mid_busy", a_busy, 0);
        chk("mid_err", a_err, 0);
        chk("mid_valid", a_sum_in_valid, 0);
        reset = 0;
        mode = 0;
        @(negedge clk);
        a_loc = 24'h000777; b_loc = 24'h000888; a_lsv = 1; b_lsv = 1;
        qa.push_back('{24'h000888, cyc + 6});
        qb.push_back('{24'h000777, cyc + 6});
        @(negedge clk); a_lsv = 0; b_lsv = 0;
        repeat (8) @(negedge clk);
        chk("post_a_err", a_err, 0);
        chk("post_a_rounds", a_round_cnt, 1);
        chk("post_b_rounds", b_round_cnt, 1);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
